// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl: SPI initiator for the LTC2308 8-channel 12-bit ADC.
// Round-robins single-ended unipolar conversions over channels 0..NUM_CH-1 and
// emits each result with its channel tag as a one-cycle strobe.
//
// Ports:
//   CLK_50       in   system clock (only clock)
//   reset        in   synchronous, active-high reset
//   enable       in   level, 1 = run scan frames
//   ADC_CONVST   out  conversion start
//   ADC_SCK      out  serial clock, idles low
//   ADC_SDI      out  6-bit config word, MSB first
//   ADC_SDO      in   conversion data, sampled at the end of each SCK high phase
//   sample_valid out  one-cycle result strobe
//   sample_data  out  12-bit unsigned result, held until the next strobe
//   sample_ch    out  channel the result belongs to, held until the next strobe
//   busy         out  1 whenever the controller is not idle
//
// The config word sent in one frame selects the conversion read back in the
// next frame, so the first frame after leaving idle is discarded.
module ltc2308_scan_ctrl #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CONV_CYC = 80,
  parameter int unsigned SCK_HALF = 2,
  parameter int unsigned ACQ_CYC  = 20
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        enable,
  output logic        ADC_CONVST,
  output logic        ADC_SCK,
  output logic        ADC_SDI,
  input  logic        ADC_SDO,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        busy
);

  localparam int unsigned CntMax = (CONV_CYC > ACQ_CYC) ? CONV_CYC : ACQ_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PhW    = $clog2(2 * SCK_HALF);

  localparam logic [CntW-1:0] ConvLast = CntW'(CONV_CYC - 1);
  localparam logic [CntW-1:0] AcqLast  = CntW'(ACQ_CYC - 1);
  localparam logic [PhW-1:0]  PhHigh   = PhW'(SCK_HALF);
  localparam logic [PhW-1:0]  PhLast   = PhW'(2 * SCK_HALF - 1);
  localparam logic [2:0]      ChLast   = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StConv, StGap, StShift, StAcq} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [PhW-1:0]  ph_q;
  logic [3:0]      bit_q;
  logic [2:0]      ch_q, prev_ch_q;
  logic            discard_q;
  logic [11:0]     shift_q;
  logic            valid_q;
  logic [11:0]     data_q;
  logic [2:0]      sch_q;

  logic [5:0]      cfg;
  logic            last_bit;
  logic [2:0]      ch_next;

  // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep
  assign cfg      = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 1'b0};
  // Final cycle of the high phase of bit 11
  assign last_bit = (bit_q == 4'd11) && (ph_q == PhLast);
  assign ch_next  = (ch_q == ChLast) ? 3'd0 : ch_q + 3'd1;

  // State register
  always_ff @(posedge CLK_50) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StConv;
      StConv:  if (cnt_q == ConvLast) state_d = StGap;
      StGap:   state_d = StShift;
      StShift: if (last_bit) state_d = StAcq;
      StAcq:   if (cnt_q == AcqLast) state_d = enable ? StConv : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters, shift register, channel bookkeeping and result registers
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      cnt_q     <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      ch_q      <= '0;
      prev_ch_q <= '0;
      discard_q <= 1'b1;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sch_q     <= '0;
    end else begin
      valid_q <= 1'b0;

      // Dwell counter for CONV and ACQ; restarts on every state change
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == StConv || state_q == StAcq) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == StShift) begin
        if (ph_q == PhLast) begin
          ph_q    <= '0;
          bit_q   <= bit_q + 4'd1;
          shift_q <= {shift_q[10:0], ADC_SDO};
        end else begin
          ph_q <= ph_q + 1'b1;
        end
      end else begin
        ph_q  <= '0;
        bit_q <= '0;
      end

      if (state_q == StIdle && state_d == StConv) begin
        ch_q      <= '0;
        prev_ch_q <= '0;
        discard_q <= 1'b1;
      end

      // Entering ACQ: publish the word read this frame, which belongs to the
      // channel configured in the previous frame
      if (state_q == StShift && state_d == StAcq) begin
        valid_q <= ~discard_q;
        if (!discard_q) begin
          data_q <= {shift_q[10:0], ADC_SDO};
          sch_q  <= prev_ch_q;
        end
        discard_q <= 1'b0;
        prev_ch_q <= ch_q;
        ch_q      <= ch_next;
      end
    end
  end

  // Pin outputs
  always_comb begin
    ADC_CONVST = 1'b0;
    ADC_SCK    = 1'b0;
    ADC_SDI    = 1'b0;
    busy       = (state_q != StIdle);
    unique case (state_q)
      StConv: ADC_CONVST = 1'b1;
      StGap:  ADC_SDI = cfg[5];
      StShift: begin
        ADC_SCK = (ph_q >= PhHigh);
        if (bit_q < 4'd6) ADC_SDI = cfg[3'd5 - bit_q[2:0]];
      end
      default: ;
    endcase
  end

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_ch    = sch_q;

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Testbench for ltc2308_scan_ctrl. Two instances run on one clock: dut_a with
// NUM_CH=8 and dut_b with NUM_CH=3, both with default timing parameters.
// A frame-position model predicts every output each cycle; directed phases pin
// the model with hand-computed literals.
module tb_ltc2308_scan_ctrl;

  localparam int Conv     = 80;
  localparam int Half     = 2;
  localparam int Acq      = 20;
  localparam int ShStart  = Conv + 1;            // 81
  localparam int AcqStart = ShStart + 24 * Half; // 129
  localparam int Frame    = AcqStart + Acq;      // 149

  logic clk = 1'b0;
  initial forever #10 clk = ~clk;

  logic rst_a, en_a, sdo_a, convst_a, sck_a, sdi_a, valid_a, busy_a;
  logic [11:0] data_a;
  logic [2:0]  ch_a;
  logic rst_b, en_b, sdo_b, convst_b, sck_b, sdi_b, valid_b, busy_b;
  logic [11:0] data_b;
  logic [2:0]  ch_b;

  ltc2308_scan_ctrl #(.NUM_CH(8)) dut_a (
    .CLK_50(clk), .reset(rst_a), .enable(en_a),
    .ADC_CONVST(convst_a), .ADC_SCK(sck_a), .ADC_SDI(sdi_a), .ADC_SDO(sdo_a),
    .sample_valid(valid_a), .sample_data(data_a), .sample_ch(ch_a), .busy(busy_a)
  );

  ltc2308_scan_ctrl #(.NUM_CH(3)) dut_b (
    .CLK_50(clk), .reset(rst_b), .enable(en_b),
    .ADC_CONVST(convst_b), .ADC_SCK(sck_b), .ADC_SDI(sdi_b), .ADC_SDO(sdo_b),
    .sample_valid(valid_b), .sample_data(data_b), .sample_ch(ch_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run [2];
  int          m_p   [2];
  int          m_k   [2];
  logic [11:0] m_data[2];
  logic [2:0]  m_ch  [2];

  function automatic int nch(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  function automatic logic [5:0] cfg_word(input int c);
    logic [2:0] b;
    b = c[2:0];
    return {1'b1, b[0], b[2], b[1], 1'b1, 1'b0};
  endfunction

  // Word the ADC model returns in frame k; dut_b gets the data of channel k-1
  function automatic logic [11:0] sdo_word(input int i, input int k);
    logic [11:0] pat [3];
    pat[0] = 12'h000;
    pat[1] = 12'hFFF;
    pat[2] = 12'h800;
    if (i == 0) return 12'hA5C;
    if (k == 0) return 12'h3C3;
    return pat[(k - 1) % 3];
  endfunction

  // {convst, sck, sdi, busy, valid} at position p of frame k
  function automatic logic [4:0] exp_pins(input bit run, input int p, input int k, input int n);
    logic [5:0] cfg;
    logic cv, sk, sd, vl;
    int s, b;
    cv = 1'b0; sk = 1'b0; sd = 1'b0; vl = 1'b0;
    if (!run) return 5'b0;
    cfg = cfg_word(k % n);
    if (p < Conv) cv = 1'b1;
    else if (p < ShStart) sd = cfg[5];
    else if (p < AcqStart) begin
      s  = p - ShStart;
      b  = s / (2 * Half);
      sk = ((s % (2 * Half)) >= Half);
      if (b < 6) sd = cfg[5 - b];
    end else if (p == AcqStart) vl = (k >= 1);
    return {cv, sk, sd, 1'b1, vl};
  endfunction

  function automatic logic sdo_bit(input int i);
    logic [11:0] w;
    int b;
    if (!m_run[i] || m_p[i] < ShStart || m_p[i] >= AcqStart) return 1'b0;
    b = (m_p[i] - ShStart) / (2 * Half);
    w = sdo_word(i, m_k[i]);
    return w[11 - b];
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      bit r, e;
      r = (i == 0) ? rst_a : rst_b;
      e = (i == 0) ? en_a : en_b;
      if (r) begin
        m_run[i] = 1'b0; m_p[i] = 0; m_k[i] = 0; m_data[i] = '0; m_ch[i] = '0;
      end else if (!m_run[i]) begin
        if (e) begin m_run[i] = 1'b1; m_p[i] = 0; m_k[i] = 0; end
      end else if (m_p[i] == Frame - 1) begin
        if (e) begin m_p[i] = 0; m_k[i]++; end
        else m_run[i] = 1'b0;
      end else begin
        m_p[i]++;
      end
      if (!r && m_run[i] && m_p[i] == AcqStart && m_k[i] >= 1) begin
        m_data[i] = sdo_word(i, m_k[i]);
        m_ch[i]   = 3'((m_k[i] - 1) % nch(i));
      end
    end
  end

  // ADC data model: presents the current bit of the frame word for the whole bit
  initial begin
    sdo_a = 1'b0;
    sdo_b = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sdo_a = sdo_bit(0);
      sdo_b = sdo_bit(1);
    end
  end

  // ---------------- per-cycle compare and pin monitor ----------------
  int cyc = 0, last_rise = -1, conv_run = 0, high_run = 0, low_run = 0, pulses = 0, ovl = 0;
  int per_min = 1000000, per_max = 0, conv_min = 1000000, conv_max = 0;
  int high_min = 1000000, high_max = 0, low_min = 1000000, low_max = 0;
  int pul_min = 1000000, pul_max = 0;
  bit frame_seen = 1'b0, pconv = 1'b0, psck = 1'b0;
  int bitcnt = 0, nseen = 0;
  logic [5:0] cfg_cur = '0;
  logic [5:0] cfg_seen [16];

  task automatic upd(inout int mn, inout int mx, input int v);
    if (v < mn) mn = v;
    if (v > mx) mx = v;
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("cycle_a", {12'b0, convst_a, sck_a, sdi_a, busy_a, valid_a, data_a, ch_a},
            {12'b0, exp_pins(m_run[0], m_p[0], m_k[0], 8), m_data[0], m_ch[0]});
      check("cycle_b", {12'b0, convst_b, sck_b, sdi_b, busy_b, valid_b, data_b, ch_b},
            {12'b0, exp_pins(m_run[1], m_p[1], m_k[1], 3), m_data[1], m_ch[1]});
    end
    if (mon_on) begin
      cyc++;
      if (convst_a && !pconv) begin
        if (last_rise >= 0) upd(per_min, per_max, cyc - last_rise);
        last_rise = cyc;
        if (frame_seen) upd(pul_min, pul_max, pulses);
        frame_seen = 1'b1; pulses = 0; bitcnt = 0;
      end
      if (convst_a) conv_run++;
      else if (pconv) begin upd(conv_min, conv_max, conv_run); conv_run = 0; end
      if (sck_a && !psck) begin
        if (pulses > 0) upd(low_min, low_max, low_run);
        low_run = 0;
        pulses++;
        if (bitcnt < 6) begin
          cfg_cur = {cfg_cur[4:0], sdi_a};
          bitcnt++;
          if (bitcnt == 6 && nseen < 16) begin cfg_seen[nseen] = cfg_cur; nseen++; end
        end
      end
      if (sck_a) high_run++;
      else begin
        if (psck) begin upd(high_min, high_max, high_run); high_run = 0; end
        low_run++;
      end
      if (sck_a && convst_a) ovl++;
      pconv = convst_a;
      psck  = sck_a;
    end
  end

  // Returns n = cycles from the current cycle to the strobe cycle
  task automatic wait_strobe_a(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      if (valid_a) begin ok = 1'b1; break; end
      @(posedge clk);
      n++;
    end
  endtask

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: time limit reached, got no end, expected $finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] exp_cfg [9] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110, 6'b101010,
                              6'b111010, 6'b101110, 6'b111110, 6'b100010};

  // ---------------- directed stimulus ----------------
  initial begin
    int n, m, hits, ns, since;
    bit ok;
    logic [2:0]  got_ch [4];
    logic [11:0] got_d  [4];
    logic [11:0] held;

    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("reset_state_a", {12'b0, convst_a, sck_a, sdi_a, busy_a, valid_a, data_a, ch_a}, 0);
    check("reset_state_b", {12'b0, convst_b, sck_b, sdi_b, busy_b, valid_b, data_b, ch_b}, 0);

    // Phase A: continuous scan, first-strobe latency, config words, pin timing
    mon_on = 1'b1;
    @(posedge clk); #1; en_a = 1'b1;
    @(posedge clk);  // enable sampled here: next cycle is frame 0, position 0
    wait_strobe_a(400, n, ok);
    check("first_strobe_seen", 32'(ok), 1);
    check("first_strobe_cycle", n, 278);  // frame 1 start (149) + first ACQ cycle (129)
    check("first_strobe_data", 32'(data_a), 32'hA5C);
    check("first_strobe_ch", 32'(ch_a), 0);
    for (int i = 0; i < 1500 && nseen < 9; i++) @(posedge clk);
    mon_on = 1'b0;
    check("cfg_words_seen", 32'(nseen >= 9), 1);
    for (int i = 0; i < 9; i++) check($sformatf("cfg_frame%0d", i), 32'(cfg_seen[i]), 32'(exp_cfg[i]));
    check("convst_width_min", conv_min, 80);
    check("convst_width_max", conv_max, 80);
    check("frame_period_min", per_min, 149);
    check("frame_period_max", per_max, 149);
    check("sck_high_min", high_min, 2);
    check("sck_high_max", high_max, 2);
    check("sck_low_min", low_min, 2);
    check("sck_low_max", low_max, 2);
    check("sck_pulses_min", pul_min, 12);
    check("sck_pulses_max", pul_max, 12);
    check("sck_during_convst", ovl, 0);

    // Phase B: drop enable at the middle of SHIFT in frame 3
    #1; en_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_a) begin ok = 1'b1; break; end
    end
    check("idle_before_phase_b", 32'(ok), 1);
    @(posedge clk); #1; en_a = 1'b1;
    @(posedge clk);
    repeat (3 * Frame + ShStart + 12 * Half) @(posedge clk);  // cycle 552
    #1; en_a = 1'b0;
    wait_strobe_a(100, n, ok);
    check("drop_strobe_seen", 32'(ok), 1);
    check("drop_strobe_delay", n, 24);
    check("drop_strobe_ch", 32'(ch_a), 2);
    check("drop_strobe_data", 32'(data_a), 32'hA5C);
    m = 0;
    while (m < 100) begin
      @(posedge clk);
      m++;
      @(negedge clk);
      if (!busy_a) break;
    end
    check("busy_fall_delay", m, 20);
    hits = 0;
    repeat (300) begin
      @(negedge clk);
      if (convst_a) hits++;
    end
    check("no_convst_after_drop", hits, 0);

    // Phase C: one-cycle reset during SHIFT bit 5 of frame 1
    @(posedge clk); #1; en_a = 1'b1;
    @(posedge clk);
    repeat (Frame + ShStart + 10 * Half + 1) @(posedge clk);  // frame 1, position 102
    #1; rst_a = 1'b1; en_a = 1'b0;
    @(posedge clk); #1; rst_a = 1'b0;
    @(negedge clk);
    check("reset_abort_outputs", {12'b0, convst_a, sck_a, sdi_a, busy_a, valid_a, data_a, ch_a}, 0);
    repeat (5) @(posedge clk);
    #1; en_a = 1'b1;
    @(posedge clk);
    wait_strobe_a(400, n, ok);
    check("restart_strobe_seen", 32'(ok), 1);
    check("restart_strobe_cycle", n, 278);
    check("restart_strobe_ch", 32'(ch_a), 0);
    check("restart_strobe_data", 32'(data_a), 32'hA5C);
    @(posedge clk); #1; en_a = 1'b0;

    // Phase D: NUM_CH=3 with channel-dependent data
    @(posedge clk); #1; en_b = 1'b1;
    ns = 0; since = -1; held = '0;
    for (int i = 0; i < 1000 && ns < 4; i++) begin
      @(negedge clk);
      if (valid_b) begin
        got_ch[ns] = ch_b; got_d[ns] = data_b; ns++; since = 0;
      end else if (since >= 0) since++;
      if (ns == 2 && since == 10) held = data_b;
      @(posedge clk);
    end
    check("b_strobes_seen", ns, 4);
    check("b_ch0", 32'(got_ch[0]), 0);
    check("b_ch1", 32'(got_ch[1]), 1);
    check("b_ch2", 32'(got_ch[2]), 2);
    check("b_ch3", 32'(got_ch[3]), 0);
    check("b_data0", 32'(got_d[0]), 32'h000);
    check("b_data1", 32'(got_d[1]), 32'hFFF);
    check("b_data2", 32'(got_d[2]), 32'h800);
    check("b_data3", 32'(got_d[3]), 32'h000);
    check("b_data_hold", 32'(held), 32'hFFF);
    #1; en_b = 1'b0;
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
